// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares the framebuffer write port between draw engines (round-robin per primitive) and a full-screen clear sequencer
module fb_write_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W = 17,
   parameter int DATA_W = 9,
   parameter int FB_SIZE = 96000,
   parameter logic [DATA_W-1:0] CLEAR_COLOR = 9'h1FF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      clear_req,
   output logic                      clear_busy,
   output logic                      clear_done,
   input  logic                      fb_ready,
   output logic                      fb_we,
   output logic [ADDR_W-1:0]         fb_addr,
   output logic [DATA_W-1:0]         fb_data,
   output logic                      oob_err
);
   localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FB_SIZE - 1);
   typedef enum logic [1:0] {IDLE, OWN, CLEAR} state_t;
   state_t state, state_nxt;
   logic [PW-1:0] owner, rr_ptr, pick;
   logic [ADDR_W-1:0] clr_cnt, sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic clr_pend, sel_valid, sel_last, accept, oob, wr_beat, clr_wr, clr_end;
   // round-robin pick (scan from farthest to nearest so the nearest valid wins) and the owner's current beat
   always_comb begin
      pick = rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) pick = PW'((int'(rr_ptr) + k) % NUM_REQ);
      sel_valid = req_valid[owner];
      sel_last = req_last[owner];
      sel_addr = req_addr[int'(owner) * ADDR_W +: ADDR_W];
      sel_data = req_data[int'(owner) * DATA_W +: DATA_W];
      accept = state == OWN && sel_valid && fb_ready;
      oob = sel_addr > LAST_IDX;
      wr_beat = accept && !oob;
      clr_wr = state == CLEAR && fb_ready;
      clr_end = clr_wr && clr_cnt == LAST_IDX;
   end
   // state register
   always_ff @(posedge clk)
      state <= reset ? IDLE : state_nxt;
   // next state: a pending clear beats requesters in IDLE; ownership ends only on an accepted last beat
   always_comb
      state_nxt = state == IDLE ? (clr_pend ? CLEAR : ((|req_valid) ? OWN : IDLE))
                : state == OWN ? ((accept && sel_last) ? IDLE : OWN)
                : (clr_end ? IDLE : CLEAR);
   // handshake and status outputs
   always_comb begin
      req_ready = (state == OWN && fb_ready) ? NUM_REQ'(1) << owner : '0;
      clear_busy = clr_pend || state == CLEAR;
   end
   // arbitration bookkeeping, clear progress and registered write port
   always_ff @(posedge clk) begin
      if (reset) begin
         owner <= '0;
         rr_ptr <= '0;
         clr_cnt <= '0;
         clr_pend <= 1'b0;
         fb_we <= 1'b0;
         fb_addr <= '0;
         fb_data <= '0;
         clear_done <= 1'b0;
         oob_err <= 1'b0;
      end else begin
         if (state == IDLE && !clr_pend && |req_valid) owner <= pick;
         if (accept && sel_last) rr_ptr <= owner == PW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
         if (state == IDLE && clr_pend) clr_cnt <= '0;
         else if (clr_wr) clr_cnt <= clr_cnt + 1'b1;
         if (clr_end) clr_pend <= 1'b0;
         else if (clear_req && state != CLEAR) clr_pend <= 1'b1;
         fb_we <= clr_wr || wr_beat;
         if (clr_wr) begin
            fb_addr <= clr_cnt;
            fb_data <= CLEAR_COLOR;
         end else if (wr_beat) begin
            fb_addr <= sel_addr;
            fb_data <= sel_data;
         end
         clear_done <= clr_end;
         oob_err <= oob_err || (accept && oob);
      end
   end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed scenarios plus randomized traffic checked every cycle against a behavioural model
module tb_fb_write_arbiter;
   localparam int N = 2, AW = 17, DW = 9, FB = 128;
   localparam logic [DW-1:0] CLR = 9'h1FF;
   logic clk = 1'b0, reset = 1'b1;
   logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_data = '0;
   logic clear_req = 1'b0, fb_ready = 1'b0;
   logic clear_busy, clear_done, fb_we, oob_err;
   logic [AW-1:0] fb_addr;
   logic [DW-1:0] fb_data;
   int checks = 0, errors = 0, cyc = 0;
   bit chk_en = 0;

   fb_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .FB_SIZE(FB), .CLEAR_COLOR(CLR)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .clear_req(clear_req), .clear_busy(clear_busy),
      .clear_done(clear_done), .fb_ready(fb_ready), .fb_we(fb_we), .fb_addr(fb_addr),
      .fb_data(fb_data), .oob_err(oob_err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // behavioural model: who holds the port, whose turn is next, clear progress
   int m_mode = 0, m_who = 0, m_turn = 0, m_pos = 0, was = 0, a = 0;
   bit m_pend = 0;
   logic e_we = 0, e_done = 0, e_oob = 0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_data = '0;
   always @(posedge clk) begin
      if (reset) begin
         m_mode = 0; m_who = 0; m_turn = 0; m_pos = 0; m_pend = 0;
         e_we = 0; e_done = 0; e_oob = 0; e_addr = '0; e_data = '0;
      end else begin
         was = m_mode;
         e_we = 0;
         e_done = 0;
         if (m_mode == 0) begin
            if (m_pend) begin
               m_mode = 2;
               m_pos = 0;
            end else if (req_valid != 0) begin
               m_who = m_turn;
               while (!req_valid[m_who]) m_who = (m_who + 1) % N;
               m_mode = 1;
            end
         end else if (m_mode == 1) begin
            if (req_valid[m_who] && fb_ready) begin
               a = int'(req_addr[m_who*AW +: AW]);
               if (a < FB) begin
                  e_we = 1;
                  e_addr = AW'(a);
                  e_data = req_data[m_who*DW +: DW];
               end else e_oob = 1;
               if (req_last[m_who]) begin
                  m_mode = 0;
                  m_turn = (m_who + 1) % N;
               end
            end
         end else if (fb_ready) begin
            e_we = 1;
            e_addr = AW'(m_pos);
            e_data = CLR;
            if (m_pos == FB - 1) begin
               m_mode = 0;
               m_pend = 0;
               e_done = 1;
            end
            m_pos++;
         end
         if (clear_req && was != 2) m_pend = 1;
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) if (chk_en) begin
      check("req_ready", req_ready, (m_mode == 1 && fb_ready) ? (1 << m_who) : 0);
      check("fb_we", fb_we, e_we);
      check("fb_addr", fb_addr, e_addr);
      check("fb_data", fb_data, e_data);
      check("clear_busy", clear_busy, m_pend || m_mode == 2);
      check("clear_done", clear_done, e_done);
      check("oob_err", oob_err, e_oob);
   end

   // write log used by the directed scenarios
   int w_cyc[$], d_cyc[$];
   logic [AW-1:0] w_addr[$];
   logic [DW-1:0] w_data[$];
   always @(negedge clk) if (chk_en) begin
      if (fb_we) begin
         w_cyc.push_back(cyc);
         w_addr.push_back(fb_addr);
         w_data.push_back(fb_data);
      end
      if (clear_done) d_cyc.push_back(cyc);
   end

   // requester drivers
   int rem[N], nxt[N];
   bit gen[N];
   int plen = 0, pstart = 0, pvalid = 100, pready = 100, poob = 0;
   bit rdy_toggle = 0;
   logic [N-1:0] acc;

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i] = rem[i] > 0 && $urandom_range(0, 99) < pvalid;
         req_last[i] = rem[i] == 1;
         req_addr[i*AW +: AW] = AW'(nxt[i]);
         req_data[i*DW +: DW] = DW'($urandom);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      acc = req_valid & req_ready;
      #1;
      clear_req = 1'b0;
      fb_ready = rdy_toggle ? !fb_ready : ($urandom_range(0, 99) < pready);
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            rem[i]--;
            nxt[i]++;
         end
         if (rem[i] == 0 && gen[i] && $urandom_range(0, 99) < pstart) begin
            rem[i] = plen != 0 ? plen : int'($urandom_range(1, 4));
            nxt[i] = $urandom_range(0, 99) < poob ? FB + int'($urandom_range(0, 900)) : i * 64 + int'($urandom_range(0, 59));
         end
      end
      drive();
   endtask

   task automatic wlog_clear();
      w_cyc.delete();
      w_addr.delete();
      w_data.delete();
      d_cyc.delete();
   endtask

   initial begin
      int vcyc, n;
      bit ok;
      logic [AW-1:0] exp_q[$];
      for (int i = 0; i < N; i++) begin
         rem[i] = 0;
         nxt[i] = 0;
         gen[i] = 0;
      end
      drive();
      repeat (2) @(posedge clk);
      #1 chk_en = 1;
      @(negedge clk);
      check("rst_fb_we", fb_we, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_clear_busy", clear_busy, 0);
      check("rst_oob_err", oob_err, 0);
      check("rst_fb_addr", fb_addr, 0);
      reset = 1'b0;
      // single requester, three beats
      tick();
      wlog_clear();
      rem[0] = 3;
      nxt[0] = 100;
      drive();
      vcyc = cyc;
      n = 0;
      while (rem[0] > 0 && n < 20) begin tick(); n++; end
      check("t1_timeout", n < 20, 1);
      repeat (3) tick();
      check("t1_count", w_addr.size(), 3);
      check("t1_addr0", w_addr[0], 100);
      check("t1_addr1", w_addr[1], 101);
      check("t1_addr2", w_addr[2], 102);
      check("t1_latency", w_cyc[0] - vcyc, 2);
      check("t1_back_to_back", w_cyc[2] - w_cyc[0], 2);
      // round robin with continuous two-beat primitives
      wlog_clear();
      gen[0] = 1; gen[1] = 1; plen = 2; pstart = 100; poob = 0;
      repeat (40) tick();
      gen[0] = 0; gen[1] = 0;
      n = 0;
      while ((rem[0] > 0 || rem[1] > 0) && n < 50) begin tick(); n++; end
      check("rr_timeout", n < 50, 1);
      repeat (3) tick();
      ok = w_addr.size() >= 8 && w_addr.size() % 2 == 0;
      for (int j = 1; j < w_addr.size(); j++) begin
         if (w_cyc[j] - w_cyc[j-1] != ((j % 2) != 0 ? 1 : 2)) ok = 0;
         if ((w_addr[j] >= 64) != ((w_addr[j-1] >= 64) ^ (j % 2 == 0))) ok = 0;
      end
      check("rr_alternate", ok, 1);
      // clear with fb_ready toggling, requester waiting behind it
      wlog_clear();
      rdy_toggle = 1;
      clear_req = 1'b1;
      tick();
      rem[0] = 2;
      nxt[0] = 20;
      drive();
      n = 0;
      while (d_cyc.size() == 0 && n < 400) begin tick(); n++; end
      check("clr_timeout", n < 400, 1);
      repeat (10) tick();
      rdy_toggle = 0;
      ok = w_addr.size() == FB + 2;
      for (int j = 0; j < FB && j < w_addr.size(); j++)
         if (w_addr[j] != AW'(j) || w_data[j] != CLR) ok = 0;
      check("clr_writes", ok, 1);
      check("clr_done_count", d_cyc.size(), 1);
      check("clr_done_at_last", d_cyc[0], w_cyc[FB-1]);
      check("clr_then_req", w_addr[FB], 20);
      // clear requested mid-primitive, second clear during CLEAR ignored
      wlog_clear();
      rem[1] = 4;
      nxt[1] = 70;
      drive();
      n = 0;
      while (rem[1] > 2 && n < 20) begin tick(); n++; end
      clear_req = 1'b1;
      rem[0] = 2;
      nxt[0] = 5;
      drive();
      repeat (20) tick();
      clear_req = 1'b1;
      n = 0;
      while (rem[0] > 0 && n < 600) begin tick(); n++; end
      check("mid_timeout", n < 600, 1);
      repeat (3) tick();
      exp_q.delete();
      for (int j = 70; j < 74; j++) exp_q.push_back(AW'(j));
      for (int j = 0; j < FB; j++) exp_q.push_back(AW'(j));
      exp_q.push_back(5);
      exp_q.push_back(6);
      ok = w_addr.size() == exp_q.size();
      for (int j = 0; j < exp_q.size() && j < w_addr.size(); j++)
         if (w_addr[j] != exp_q[j]) ok = 0;
      check("mid_clear_order", ok, 1);
      check("mid_clear_done", d_cyc.size(), 1);
      // out-of-bounds beat
      wlog_clear();
      rem[0] = 1;
      nxt[0] = 96000;
      drive();
      n = 0;
      while (rem[0] > 0 && n < 20) begin tick(); n++; end
      rem[1] = 1;
      nxt[1] = 80;
      drive();
      while (rem[1] > 0 && n < 40) begin tick(); n++; end
      check("oob_timeout", n < 40, 1);
      repeat (5) tick();
      check("oob_sticky", oob_err, 1);
      check("oob_writes", w_addr.size(), 1);
      check("oob_next_prim", w_addr[0], 80);
      // reset in the middle of a clear
      wlog_clear();
      clear_req = 1'b1;
      n = 0;
      while (!(fb_we && fb_addr == 6) && n < 300) begin tick(); n++; end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rr_fb_we", fb_we, 0);
      check("rr_fb_addr", fb_addr, 0);
      check("rr_fb_data", fb_data, 0);
      check("rr_busy", clear_busy, 0);
      check("rr_oob", oob_err, 0);
      check("rr_ready", req_ready, 0);
      repeat (10) tick();
      check("rr_no_writes", w_addr.size(), 7);
      wlog_clear();
      clear_req = 1'b1;
      n = 0;
      while (d_cyc.size() == 0 && n < 300) begin tick(); n++; end
      repeat (2) tick();
      check("rr_restart_addr0", w_addr[0], 0);
      check("rr_restart_count", w_addr.size(), FB);
      // randomized traffic
      gen[0] = 1; gen[1] = 1; plen = 0; pstart = 30; pvalid = 75; pready = 70; poob = 12;
      for (int t = 0; t < 4000; t++) begin
         tick();
         if ($urandom_range(0, 299) == 0) clear_req = 1'b1;
         reset = $urandom_range(0, 1999) == 0;
      end
      reset = 1'b0;
      gen[0] = 0; gen[1] = 0;
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
